// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op classification helpers for the
// bit-serial ALU.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_SLT  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_NAND = 3'b101;
   localparam logic [2:0] OP_NOR  = 3'b110;
   localparam logic [2:0] OP_OR   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic op_is_arith(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
   endfunction

   // SUB and SLT run A + ~B + 1: B inverted in the slice, carry seeded with 1.
   function automatic logic op_is_sub(input logic [2:0] op);
      return (op == OP_SUB) || (op == OP_SLT);
   endfunction

endpackage

// File: rtl/alu_serial_if.sv
// Request/response handshake bundle between the sequencer and the serial ALU.
interface alu_serial_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_carry;
   logic             out_zero;
   logic             out_overflow;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result, out_carry, out_zero, out_overflow
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result, out_carry, out_zero, out_overflow
   );
endinterface

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: invert-B full adder plus bitwise logic ops, 8:1 select on op.
module alu_bit_slice
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic [2:0] op,
   output logic       r,
   output logic       cout
);

   logic bx;
   logic sum;

   always_comb begin
      bx   = b ^ op_is_sub(op);
      sum  = a ^ bx ^ cin;
      cout = (a & bx) | (a & cin) | (bx & cin);
      case (op)
         OP_ADD, OP_SUB, OP_SLT: r = sum;
         OP_XOR:                 r = a ^ b;
         OP_AND:                 r = a & b;
         OP_NAND:                r = ~(a & b);
         OP_NOR:                 r = ~(a | b);
         default:                r = a | b;
      endcase
   end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU: one result bit per clock, LSB first, through a single slice.
// Result and flags are registered and held in DONE until the response handshake.
module alu_serial
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
)(
   input  logic         clk,
   input  logic         rst_n,
   alu_serial_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [2:0]       op_q, op_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cflag_q, cflag_d, vflag_q, vflag_d, zflag_q, zflag_d;
   logic             slice_r, slice_cout, ovf;

   alu_bit_slice u_slice (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .op   (op_q),
      .r    (slice_r),
      .cout (slice_cout)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      res_d   = res_q;
      cflag_d = cflag_q;
      vflag_d = vflag_q;
      zflag_d = zflag_q;
      ovf     = carry_q ^ slice_cout;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               op_d    = bus.in_op;
               cnt_d   = '0;
               carry_d = op_is_sub(bus.in_op);
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Operands shift right so the slice always sees bit cnt at position 0.
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            res_d   = {slice_r, res_q[WIDTH-1:1]};
            carry_d = slice_cout;
            if (cnt_q == CNT_LAST) begin
               if (op_q == OP_SLT) begin
                  res_d    = '0;
                  res_d[0] = slice_r ^ ovf;
               end
               cflag_d = op_is_arith(op_q) & slice_cout;
               vflag_d = op_is_arith(op_q) & ovf;
               zflag_d = (res_d == '0);
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         res_q   <= '0;
         cflag_q <= 1'b0;
         vflag_q <= 1'b0;
         zflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         cflag_q <= cflag_d;
         vflag_q <= vflag_d;
         zflag_q <= zflag_d;
      end
   end

   assign bus.in_ready     = (state_q == S_IDLE);
   assign bus.out_valid    = (state_q == S_DONE);
   assign bus.out_result   = res_q;
   assign bus.out_carry    = cflag_q;
   assign bus.out_zero     = zflag_q;
   assign bus.out_overflow = vflag_q;

endmodule

// File: doc/alu_serial.md
# alu_serial

Bit-serial WIDTH-bit ALU that computes one result bit per clock, LSB first, through a single 1-bit ALU slice. Operands and an operation code are accepted over a valid/ready request port. The WIDTH-bit result and flags (carry, zero, overflow) are returned over a valid/ready response port. It trades latency for area and sits between an instruction sequencer and the register-file write-back.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  input  1  clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready at clk edge
- in_op  input  3  operation code
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  response valid
- out_ready  input  1  response consumed when out_valid && out_ready at clk edge
- out_result  output  WIDTH  result
- out_carry  output  1  carry out of MSB (ADD/SUB/SLT), else 0
- out_zero  output  1  1 iff out_result == 0
- out_overflow  output  1  signed overflow (ADD/SUB/SLT), else 0

## Operation
- Op codes: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR. All codes are legal.
- SUB and SLT compute A + ~B + 1. The carry register is seeded with 1 and B bits are inverted in the slice. ADD seeds the carry with 0.
- States: IDLE → RUN → DONE → IDLE.
- IDLE: in_ready=1. On accept, the block latches in_a, in_b and in_op, clears the bit counter, seeds the carry, and moves to RUN.
- Inputs are ignored outside the accept edge.
- RUN: each edge feeds the slice with A[cnt], B[cnt] and the carry. The result bit shifts into the MSB of the result shift register, the carry register updates, and cnt increments.
- At the edge processing bit WIDTH-1, the block also records overflow = carry_in(MSB) XOR carry_out(MSB) and then enters DONE.
- SLT: on entry to DONE, the result is replaced by {WIDTH-1 zeros, sum[MSB] XOR overflow}. out_carry and out_overflow still report the subtraction.
- Logic ops: out_carry=0 and out_overflow=0.
- out_zero is computed on the final (post-SLT) result.
- DONE: out_valid=1. Outputs are held stable until out_ready. On handshake, the block returns to IDLE.
- in_ready=0 in RUN and DONE, so there is no request overlap.
- Reset (any state, including mid-RUN) sets: state IDLE, in_ready=1, out_valid=0, out_result=0, all flags 0, cnt=0, carry=0. A partial operation is discarded.

## Timing
- Accept at edge E0. Bits 0..WIDTH-1 are computed at edges E1..E_WIDTH.
- out_valid is high from just after E_WIDTH, i.e. latency WIDTH cycles.
- Minimum throughput is one op per WIDTH+2 cycles: accept, WIDTH compute cycles, one DONE cycle with out_ready=1. in_ready rises the cycle after the response handshake.
- The counter is $clog2(WIDTH) bits. The terminal compare is cnt == WIDTH-1, with no wrap past WIDTH-1.
- All outputs come from registers; there is no combinational path from inputs to outputs.
- in_ready depends only on state.

## Structure
- Shared package alu_pkg:
  - op code localparams (OP_ADD … OP_OR)
  - state encoding (S_IDLE, S_RUN, S_DONE)
  - helper function op_is_arith(op)
- Sub-module alu_bit_slice, purely combinational:
  - inputs a, b, cin, op
  - outputs r, cout
  - implements the invert-B full adder, XOR, AND, NAND, NOR and OR, with an 8:1 select on op (SLT selects the sum)
- Top level holds the FSM, operand shift registers, carry/overflow registers, counter and result register.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001 → result 0x00000000, carry 1, zero 1, overflow 0, out_valid exactly 32 cycles after accept.
- SUB 0x80000000 − 0x00000001 → result 0x7FFFFFFF, carry 1, overflow 1, zero 0.
- SLT signed compares:
  - A=0x00000005, B=0xFFFFFFFD → result 0, zero 1.
  - Swapped operands → result 0x00000001, zero 0.
- XOR 0xA5A5A5A5 ^ 0xFFFF0000 → 0x5A5AA5A5. NOR 0, 0 → 0xFFFFFFFF.
  - Both: carry 0, overflow 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_* stable, in_ready=0. Toggle in_a/in_valid meanwhile → no effect. Handshake → in_ready=1 on the next cycle.
- Reset asserted at cycle 10 of RUN → out_valid=0, in_ready=1 immediately and after release. A following ADD 3+4 returns 0x00000007 with no stale state.
